fifo_ctrl_multi: RTL and testbench

- Parametrised successor to the 2-word-write / 1-word-read FIFO controller.
- Manages a word-addressed register file (depth 2**ADDR_WIDTH) as a circular queue.
- Each accepted write consumes WR_STEP words; each accepted read consumes RD_STEP words.
- Adds an occupancy count, room-aware accept rules, almost-full/almost-empty thresholds, sticky overflow/underflow flags and a synchronous flush.
- Sits between a producer/consumer pair and the dual-port register file; w_addr/r_addr drive the file directly.

---
 rtl/fifo_ctrl_multi.sv | 95 +++++++++
 tb/tb_fifo_ctrl_multi.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_multi.sv
// Pointer/count controller for a circular queue built on a dual-port
// register file. Writes move WR_STEP words and reads move RD_STEP words.
// Ports: clk, reset (sync, active-high), rd, wr, clear (sync flush),
// w_addr/r_addr (group base addresses), count, empty, full, can_wr,
// can_rd, almost_full, almost_empty, overflow/underflow (sticky).
module fifo_ctrl_multi #(
  parameter int ADDR_WIDTH = 4,
  parameter int WR_STEP    = 2,
  parameter int RD_STEP    = 1,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic                  clear,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  can_wr,
  output logic                  can_rd,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW    = ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;

  localparam logic [AW+1:0] C_DEPTH = (AW+2)'(DEPTH);
  localparam logic [AW+1:0] C_WSTEP = (AW+2)'(WR_STEP);
  localparam logic [AW+1:0] C_RSTEP = (AW+2)'(RD_STEP);
  localparam logic [AW+1:0] C_AF    = (AW+2)'(AF_THRESH);
  localparam logic [AW+1:0] C_AE    = (AW+2)'(AE_THRESH);
  // A step of DEPTH truncates to 0, which is the correct modulo move.
  localparam logic [AW-1:0] C_WINC  = AW'(WR_STEP);
  localparam logic [AW-1:0] C_RINC  = AW'(RD_STEP);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          r_unf;

  logic [AW+1:0] w_cnt_ext;
  logic [AW+1:0] w_cnt_nxt;
  logic          w_wr_acc;
  logic          w_rd_acc;

  assign w_cnt_ext = {1'b0, r_count};

  assign can_wr = (C_DEPTH - w_cnt_ext) >= C_WSTEP;
  assign can_rd = w_cnt_ext >= C_RSTEP;

  // Each side is judged on the pre-edge count only.
  assign w_wr_acc = wr & can_wr;
  assign w_rd_acc = rd & can_rd;

  always_comb begin
    w_cnt_nxt = w_cnt_ext;
    if (w_wr_acc) w_cnt_nxt = w_cnt_nxt + C_WSTEP;
    if (w_rd_acc) w_cnt_nxt = w_cnt_nxt - C_RSTEP;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + C_WINC;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + C_RINC;
      r_count <= w_cnt_nxt[AW:0];
      if (wr && !can_wr) r_ovf <= 1'b1;
      if (rd && !can_rd) r_unf <= 1'b1;
    end
  end

  assign w_addr       = r_wr_ptr;
  assign r_addr       = r_rd_ptr;
  assign count        = r_count;
  assign empty        = (r_count == '0);
  assign full         = (w_cnt_ext == C_DEPTH);
  assign almost_full  = (w_cnt_ext >= C_AF);
  assign almost_empty = (w_cnt_ext <= C_AE);
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_fifo_ctrl_multi.sv
// Testbench for fifo_ctrl_multi: directed vector table plus randomized
// traffic compared against an arithmetic occupancy model.
module tb_fifo_ctrl_multi;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int WS    = 2;
  localparam int RS    = 1;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          can_wr;
  logic          can_rd;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int n_chk = 0;
  int n_err = 0;

  fifo_ctrl_multi #(
    .ADDR_WIDTH(AW), .WR_STEP(WS), .RD_STEP(RS),
    .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .clear(clear),
    .w_addr(w_addr), .r_addr(r_addr), .count(count),
    .empty(empty), .full(full), .can_wr(can_wr), .can_rd(can_rd),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit clr;
    bit r;
    bit w;
    int cnt;
    int wa;
    int ra;
    bit ov;
    bit un;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(bit rst, bit clr, bit r, bit w,
                            int cnt, int wa, int ra, bit ov, bit un);
    vec_t e;
    e.rst = rst; e.clr = clr; e.r = r; e.w = w;
    e.cnt = cnt; e.wa = wa; e.ra = ra; e.ov = ov; e.un = un;
    tbl.push_back(e);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Status flags follow from occupancy alone.
  function automatic int flags_of(int c);
    int f;
    f = 0;
    if (c == 0)           f |= 32;
    if (c == DEPTH)       f |= 16;
    if (DEPTH - c >= WS)  f |= 8;
    if (c >= RS)          f |= 4;
    if (c >= AF)          f |= 2;
    if (c <= AE)          f |= 1;
    return f;
  endfunction

  task automatic check_all(string tag, int cnt, int wa, int ra,
                           bit ov, bit un);
    chk({tag, ".count"}, int'(count), cnt);
    chk({tag, ".w_addr"}, int'(w_addr), wa);
    chk({tag, ".r_addr"}, int'(r_addr), ra);
    chk({tag, ".overflow"}, int'(overflow), int'(ov));
    chk({tag, ".underflow"}, int'(underflow), int'(un));
    chk({tag, ".flags"},
        int'({empty, full, can_wr, can_rd, almost_full, almost_empty}),
        flags_of(cnt));
  endtask

  task automatic cyc(bit x, bit c, bit r, bit w);
    reset = x; clear = c; rd = r; wr = w;
    @(posedge clk);
    #1;
  endtask

  // Reference model: occupancy and pointer arithmetic on integers.
  int  m_cnt, m_w, m_r;
  bit  m_ov, m_un;

  task automatic model(bit x, bit c, bit r, bit w);
    bit ok_w, ok_r;
    if (x || c) begin
      m_cnt = 0; m_w = 0; m_r = 0; m_ov = 0; m_un = 0;
    end else begin
      ok_w = (DEPTH - m_cnt) >= WS;
      ok_r = m_cnt >= RS;
      if (w && !ok_w) m_ov = 1;
      if (r && !ok_r) m_un = 1;
      if (w && ok_w) begin
        m_cnt += WS;
        m_w = (m_w + WS) % DEPTH;
      end
      if (r && ok_r) begin
        m_cnt -= RS;
        m_r = (m_r + RS) % DEPTH;
      end
    end
  endtask

  initial begin
    // Reset then idle.
    v(1,0,0,0, 0,0,0,0,0);
    v(0,0,0,0, 0,0,0,0,0);
    // Fill with 8 writes, then one rejected write.
    for (int k = 1; k <= 8; k++) v(0,0,0,1, 2*k, (2*k)%16, 0,0,0);
    v(0,0,0,1, 16,0,0,1,0);
    // Drain fully, then one rejected read.
    for (int k = 1; k <= 16; k++) v(0,0,1,0, 16-k, 0, k%16, 1,0);
    v(0,0,1,0, 0,0,0,1,1);
    // Partial room: count 15, rd+wr -> read only.
    v(0,1,0,0, 0,0,0,0,0);
    for (int k = 1; k <= 8; k++) v(0,0,0,1, 2*k, (2*k)%16, 0,0,0);
    v(0,0,1,0, 15,0,1,0,0);
    v(0,0,1,1, 14,0,2,1,0);
    // Empty, rd+wr -> write only; then both accepted.
    v(0,1,0,0, 0,0,0,0,0);
    v(0,0,1,1, 2,2,0,0,1);
    v(0,0,1,1, 3,4,1,0,1);
    // Clear beats a write; reset+clear together the same.
    v(0,1,0,0, 0,0,0,0,0);
    for (int k = 1; k <= 5; k++) v(0,0,0,1, 2*k, 2*k, 0,0,0);
    v(0,1,0,1, 0,0,0,0,0);
    for (int k = 1; k <= 5; k++) v(0,0,0,1, 2*k, 2*k, 0,0,0);
    v(1,1,0,1, 0,0,0,0,0);

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].clr, tbl[i].r, tbl[i].w);
      check_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].wa,
                tbl[i].ra, tbl[i].ov, tbl[i].un);
    end

    // Randomized traffic against the model.
    cyc(1,0,0,0);
    model(1,0,0,0);
    for (int i = 0; i < 3000; i++) begin
      bit x, c, r, w;
      x = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 79) == 0);
      r = ($urandom_range(0, 99) < 45);
      w = ($urandom_range(0, 99) < 45);
      cyc(x, c, r, w);
      model(x, c, r, w);
      check_all($sformatf("rnd%0d", i), m_cnt, m_w, m_r, m_ov, m_un);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
